// File: rtl/apb_modport_pkg.sv
// Shared types and helpers for the APB register-file completer.
//   state_e     : two-state transfer FSM encoding (IDLE, ACCESS)
//   decode_t    : address decode result {word index, error flag}
//   decode_addr : maps a byte address to a register index and flags illegal accesses
package apb_modport_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Register 0 is the read-only identification word.
    localparam int unsigned ID_REG_IDX = 32'd0;
    // Registers are word-sized; byte offset >> 2 gives the index.
    localparam int unsigned WORD_SHIFT = 32'd2;
    // Width of the decoded index carried through the design.
    localparam int unsigned IDX_W      = 32'd32;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             err;
    } decode_t;

    // Arithmetic is done at 64 bits so an address below the base or far past
    // the last register can never wrap back into the legal window.
    function automatic decode_t decode_addr(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [31:0] num_regs,
        input logic        is_write
    );
        decode_t     res;
        logic [63:0] offset;
        logic [63:0] word;
        offset    = addr - base;
        word      = offset >> WORD_SHIFT;
        res.index = word[IDX_W-1:0];
        res.err   = (offset[1:0] != 2'b00)
                 || (addr < base)
                 || (word >= {32'd0, num_regs})
                 || (is_write && (word == 64'(ID_REG_IDX)));
        return res;
    endfunction

endpackage

// File: rtl/apb_modport_slave_regfile.sv
// Register storage for the APB completer.
//   PCLK, PRESET : clock, synchronous active-high reset
//   wr_en        : commit a write of wr_data into register idx
//   idx          : register index for both write and read
//   wr_data      : data to store
//   rd_data      : contents of register idx (ID_VALUE for index 0)
//   regs_o       : all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse_o   : one-cycle pulse per register, the cycle after its write commits
module apb_modport_slave_regfile
    import apb_modport_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA2B0_0001)
)(
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    logic [NUM_REGS-1:0] pulse_r;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ID_REG_IDX) begin : g_id
            assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] reg_r;

            // Writable register storage
            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    reg_r <= '0;
                end else if (wr_en && (idx == IDX_W'(i))) begin
                    reg_r <= wr_data;
                end else begin
                    reg_r <= reg_r;
                end
            end

            assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = reg_r;
        end
    end

    // Write-pulse generation, aligned with the register update
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pulse_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pulse_r[i] <= wr_en && (idx == IDX_W'(i));
            end
        end
    end

    assign wr_pulse_o = pulse_r;

    // Read mux; an out-of-range index reads as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_data = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                rd_data = rd_data;
            end
        end
    end

endmodule

// File: rtl/apb_modport_slave.sv
// APB3 completer exposing a small configuration/status register file.
//   PCLK, PRESET      : clock, synchronous active-high reset
//   PADDR/PWRITE/PWDATA/PSEL/PENABLE : APB requester signals
//   PRDATA/PREADY/PSLVERR            : APB completer responses
//   regs_o            : flattened register contents
//   wr_pulse_o        : per-register write pulse
// Setup-phase address/data are latched; the access phase holds PREADY low for
// WAIT_STATES cycles. PSEL&PENABLE seen while idle is answered with an
// immediate error and no side effect.
module apb_modport_slave
    import apb_modport_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA2B0_0001)
)(
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int unsigned      CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    state_e                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]        idx_r, idx_nxt_s;
    logic                    err_r, err_nxt_s;
    logic                    write_r, write_nxt_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_nxt_s;
    logic                    commit_s;
    logic                    wr_en_s;
    logic                    ready_s, slverr_s, rd_en_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;
    decode_t                 dec_s;

    assign dec_s = decode_addr(64'(PADDR), 64'(BASE_ADDR), 32'(NUM_REGS), PWRITE);

    // FSM, wait counter and setup-phase latches
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            err_r   <= 1'b0;
            write_r <= 1'b0;
            wdata_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            err_r   <= err_nxt_s;
            write_r <= write_nxt_s;
            wdata_r <= wdata_nxt_s;
        end
    end

    // Next-state logic and commit decision
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        err_nxt_s   = err_r;
        write_nxt_s = write_r;
        wdata_nxt_s = wdata_r;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt_s = ACCESS;
                    cnt_nxt_s   = CNT_LOAD;
                    idx_nxt_s   = dec_s.index;
                    err_nxt_s   = dec_s.err;
                    write_nxt_s = PWRITE;
                    wdata_nxt_s = PWDATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Requester abandoned the transfer: drop it silently.
                    state_nxt_s = IDLE;
                end else if (PENABLE && (cnt_r == '0)) begin
                    commit_s    = !PRESET;
                    state_nxt_s = IDLE;
                end else if (PENABLE) begin
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign wr_en_s = commit_s && write_r && !err_r;

    // Response outputs derived from registered state
    always_comb begin
        ready_s  = 1'b0;
        slverr_s = 1'b0;
        rd_en_s  = 1'b0;
        if (PRESET) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Access phase without a setup phase: protocol violation.
                    if (PSEL && PENABLE) begin
                        ready_s  = 1'b1;
                        slverr_s = 1'b1;
                    end else begin
                        ready_s  = 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_r == '0) begin
                        ready_s  = 1'b1;
                        slverr_s = err_r;
                        rd_en_s  = !write_r && !err_r;
                    end else begin
                        ready_s  = 1'b0;
                    end
                end
                default: begin
                    ready_s = 1'b0;
                end
            endcase
        end
    end

    assign PREADY  = ready_s;
    assign PSLVERR = slverr_s;
    assign PRDATA  = rd_en_s ? rd_data_s : '0;

    apb_modport_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .wr_en      (wr_en_s),
        .idx        (idx_r),
        .wr_data    (wdata_r),
        .rd_data    (rd_data_s),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

endmodule

// File: tb/tb_apb_modport_slave.sv
// Self-checking bench: two completers (WAIT_STATES 0 and 3) share the APB
// address/data/enable lines and have their own PSEL. A word-array model of
// each register file predicts read data, error responses, pulses and regs_o.
module tb_apb_modport_slave;

    localparam logic [31:0] ID_VAL = 32'hA2B0_0001;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        penable;
    logic        psel    [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic [511:0] regs_v [2];
    logic [15:0] pulse_v [2];

    int          ws [2] = '{0, 3};
    logic [31:0] mdl [2][16];
    int          tests = 0;
    int          fails = 0;

    apb_modport_slave #(.WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PSEL(psel[0]), .PENABLE(penable),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .regs_o(regs_v[0]), .wr_pulse_o(pulse_v[0])
    );

    apb_modport_slave #(.WAIT_STATES(3)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PSEL(psel[1]), .PENABLE(penable),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .regs_o(regs_v[1]), .wr_pulse_o(pulse_v[1])
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void reset_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mdl[d][i] = 32'd0;
            mdl[d][0] = ID_VAL;
        end
    endfunction

    function automatic logic [511:0] model_flat(input int d);
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = mdl[d][i];
        return f;
    endfunction

    // One complete APB transfer on DUT d; caller is aligned just after a rising edge.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [31:0] data, input bit b2b);
        int          waits;
        int          idx;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [15:0] exp_pulse;
        idx     = int'(addr >> 2);
        exp_err = (addr[1:0] != 2'b00) || (idx >= 16) || (wr && idx == 0);
        exp_rd  = 32'd0;
        if (!exp_err && !wr) exp_rd = mdl[d][idx];
        paddr = addr; pwrite = wr; pwdata = data; psel[d] = 1'b1; penable = 1'b0;
        @(negedge PCLK);
        tests++;
        if (pready[d] !== 1'b0) begin
            fails++;
            $display("FAIL setup_pready dut%0d addr=%h: got %b want 0", d, addr, pready[d]);
        end
        @(posedge PCLK); #1;
        penable = 1'b1;
        pwdata  = $urandom;
        waits   = 0;
        @(negedge PCLK);
        while (pready[d] !== 1'b1 && waits < 20) begin
            tests++;
            if (prdata[d] !== 32'd0 || pslverr[d] !== 1'b0) begin
                fails++;
                $display("FAIL wait_outputs dut%0d addr=%h: prdata=%h pslverr=%b want 0/0",
                         d, addr, prdata[d], pslverr[d]);
            end
            waits++;
            @(posedge PCLK); #1;
            @(negedge PCLK);
        end
        tests++;
        if (waits !== ws[d]) begin
            fails++;
            $display("FAIL wait_count dut%0d addr=%h: got %0d want %0d", d, addr, waits, ws[d]);
        end
        tests++;
        if (pslverr[d] !== exp_err) begin
            fails++;
            $display("FAIL pslverr dut%0d addr=%h wr=%b: got %b want %b", d, addr, wr, pslverr[d], exp_err);
        end
        tests++;
        if (prdata[d] !== exp_rd) begin
            fails++;
            $display("FAIL prdata dut%0d addr=%h wr=%b: got %h want %h", d, addr, wr, prdata[d], exp_rd);
        end
        @(posedge PCLK); #1;
        exp_pulse = 16'd0;
        if (!exp_err && wr) begin
            mdl[d][idx] = data;
            exp_pulse   = 16'd1 << idx;
        end
        if (!b2b) begin
            psel[d] = 1'b0; penable = 1'b0;
            @(negedge PCLK);
            tests++;
            if (pulse_v[d] !== exp_pulse) begin
                fails++;
                $display("FAIL wr_pulse dut%0d addr=%h: got %h want %h", d, addr, pulse_v[d], exp_pulse);
            end
            tests++;
            if (regs_v[d] !== model_flat(d)) begin
                fails++;
                $display("FAIL regs_o dut%0d after addr=%h: slice=%h want %h", d, addr,
                         regs_v[d][(idx % 16)*32 +: 32], mdl[d][idx % 16]);
            end
            @(posedge PCLK); #1;
        end
    endtask

    task automatic test_reset();
        @(posedge PCLK); #1;
        PRESET = 1'b1; psel[0] = 1'b0; psel[1] = 1'b0; penable = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        reset_model();
        @(negedge PCLK);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'd0 || pulse_v[d] !== 16'd0) begin
                fails++;
                $display("FAIL reset_outputs dut%0d: pready=%b pslverr=%b prdata=%h pulse=%h want all 0",
                         d, pready[d], pslverr[d], prdata[d], pulse_v[d]);
            end
            tests++;
            if (regs_v[d] !== model_flat(d)) begin
                fails++;
                $display("FAIL reset_regs dut%0d: reg0=%h reg1=%h want %h 0", d,
                         regs_v[d][31:0], regs_v[d][63:32], ID_VAL);
            end
        end
        @(posedge PCLK); #1;
    endtask

    task automatic test_id_read();
        xfer(0, 32'h0, 1'b0, 32'd0, 1'b0);
        xfer(1, 32'h0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_write_read();
        xfer(0, 32'h8, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xfer(0, 32'h8, 1'b0, 32'd0, 1'b0);
        xfer(1, 32'h3C, 1'b1, 32'h1234_5678, 1'b0);
        xfer(1, 32'h3C, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_wait_states();
        xfer(1, 32'h4, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_errors();
        for (int d = 0; d < 2; d++) begin
            xfer(d, 32'h0, 1'b1, $urandom, 1'b0);
            xfer(d, 32'h40, 1'b1, $urandom, 1'b0);
            xfer(d, 32'h6, 1'b0, 32'd0, 1'b0);
            xfer(d, 32'h44, 1'b0, 32'd0, 1'b0);
        end
    endtask

    task automatic test_abort();
        @(negedge PCLK); #0;
        @(posedge PCLK); #1;
        paddr = 32'hC; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; psel[1] = 1'b1; penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        tests++;
        if (pready[1] !== 1'b0) begin
            fails++;
            $display("FAIL abort_pready: got %b want 0", pready[1]);
        end
        @(posedge PCLK); #1;
        psel[1] = 1'b0; penable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            tests++;
            if (pulse_v[1] !== 16'd0 || pslverr[1] !== 1'b0) begin
                fails++;
                $display("FAIL abort_pulse cycle %0d: pulse=%h pslverr=%b want 0", k, pulse_v[1], pslverr[1]);
            end
        end
        tests++;
        if (regs_v[1] !== model_flat(1)) begin
            fails++;
            $display("FAIL abort_regs: reg3=%h want %h", regs_v[1][127:96], mdl[1][3]);
        end
        @(posedge PCLK); #1;
        xfer(1, 32'hC, 1'b0, 32'd0, 1'b0);
        xfer(1, 32'hC, 1'b1, 32'h0BAD_CAFE, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        xfer(0, 32'h10, 1'b1, a, 1'b1);
        xfer(0, 32'h10, 1'b0, 32'd0, 1'b1);
        xfer(0, 32'h14, 1'b1, b, 1'b1);
        xfer(0, 32'h14, 1'b0, 32'd0, 1'b0);
        xfer(1, 32'h18, 1'b1, a ^ b, 1'b1);
        xfer(1, 32'h18, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          d;
            logic [31:0] addr;
            d    = int'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 17)) << 2;
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            xfer(d, addr, 1'($urandom_range(0, 1)), $urandom, 1'b0);
        end
    endtask

    task automatic test_reset_mid_and_violation();
        xfer(1, 32'h4, 1'b1, 32'h5555_AAAA, 1'b0);
        paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h1357_9BDF; psel[1] = 1'b1; penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        @(posedge PCLK); #1;
        PRESET = 1'b1; psel[1] = 1'b0; penable = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        reset_model();
        @(negedge PCLK);
        tests++;
        if (regs_v[1] !== model_flat(1) || pulse_v[1] !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid_regs: reg1=%h pulse=%h want 0 0", regs_v[1][63:32], pulse_v[1]);
        end
        tests++;
        if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0 || prdata[1] !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: pready=%b pslverr=%b prdata=%h want 0",
                     pready[1], pslverr[1], prdata[1]);
        end
        @(posedge PCLK); #1;
        paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hFFFF_0000; psel[1] = 1'b1; penable = 1'b1;
        @(negedge PCLK);
        tests++;
        if (pready[1] !== 1'b1 || pslverr[1] !== 1'b1 || prdata[1] !== 32'd0) begin
            fails++;
            $display("FAIL violation_resp: pready=%b pslverr=%b prdata=%h want 1 1 0",
                     pready[1], pslverr[1], prdata[1]);
        end
        @(posedge PCLK); #1;
        psel[1] = 1'b0; penable = 1'b0;
        @(negedge PCLK);
        tests++;
        if (regs_v[1] !== model_flat(1) || pulse_v[1] !== 16'd0) begin
            fails++;
            $display("FAIL violation_effect: reg1=%h pulse=%h want 0 0", regs_v[1][63:32], pulse_v[1]);
        end
        @(posedge PCLK); #1;
        xfer(1, 32'h4, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        PRESET = 1'b1; paddr = 32'd0; pwrite = 1'b0; pwdata = 32'd0; penable = 1'b0;
        psel[0] = 1'b0; psel[1] = 1'b0;
        reset_model();
        test_reset();
        test_id_read();
        test_write_read();
        test_wait_states();
        test_errors();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_and_violation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
